// File: rtl/vec_drain_pkg.sv
// Shared definitions for stream stages: FSM encodings and FIFO sizing helper.
package vec_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int fifo_depth(input int fw);
    return 1 << fw;
  endfunction

endpackage

// File: rtl/vec_drain_sync_fifo.sv
// Small synchronous FIFO; head entry is presented directly from storage.
module vec_drain_sync_fifo #(
  parameter int DW = 17,
  parameter int FW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [FW:0]   count
);
  localparam int DEPTH = 1 << FW;

  logic [DW-1:0] store [DEPTH];
  logic [FW-1:0] wptr;
  logic [FW-1:0] rptr;

  assign rdata = store[rptr];

  // storage, pointers and occupancy; storage is cleared so the head reads 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (push) begin
        store[wptr] <= wdata;
        wptr        <= wptr + FW'(1);
      end
      if (pop) rptr <= rptr + FW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (FW+1)'(1);
        2'b01:   count <= count - (FW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vec_drain.sv
// Reads len words from memory starting at base and streams them out with a running sum.
//
// state | meaning
// IDLE  | waiting for start; FIFO empty
// RUN   | issuing reads, gated by FIFO credit and memory stall
// DRAIN | all reads accepted; emptying FIFO until the last beat handshakes
module vec_drain
  import vec_drain_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 10,
  parameter int LW = 16,
  parameter int FW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_bsy,
  input  logic          mem_rvld,
  input  logic [W-1:0]  mem_rdata,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic [W-1:0]  sum
);
  localparam logic [FW:0] DEPTH = (FW+1)'(fifo_depth(FW));

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] rem;
  logic          inflight;
  logic          inflight_last;
  logic [FW:0]   count;
  logic [FW:0]   occ;
  logic [W:0]    head;
  logic          accept;
  logic          push;
  logic          pop;
  logic          done_nxt;

  assign accept   = mem_rd & ~mem_bsy;
  // only returns for reads we actually issued are kept, so stale data after reset is dropped
  assign push     = mem_rvld & inflight;
  assign pop      = out_vld & out_rdy;
  assign occ      = count + {{FW{1'b0}}, inflight};
  assign out_vld  = (count != '0);
  assign out_data = head[W-1:0];
  assign out_last = head[W];
  assign busy     = (state != ST_IDLE);

  vec_drain_sync_fifo #(.DW(W+1), .FW(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({inflight_last, mem_rdata}),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next state, read request with credit check, completion strobe
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) state_nxt = ST_RUN;
          else           done_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        mem_rd = (occ < DEPTH);
        if (accept && rem == LW'(1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // address/remaining counters, in-flight tracking, checksum and done register
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr      <= '0;
      rem           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      sum           <= '0;
      done          <= 1'b0;
    end else begin
      done          <= done_nxt;
      inflight      <= accept;
      inflight_last <= accept && (rem == LW'(1));
      if (state == ST_IDLE && start) begin
        mem_addr <= base;
        rem      <= len;
        sum      <= '0;
      end else begin
        if (accept) begin
          mem_addr <= mem_addr + AW'(1);
          rem      <= rem - LW'(1);
        end
        if (pop) sum <= sum + out_data;
      end
    end
  end

endmodule

// File: tb/tb_vec_drain.sv
// Randomized scoreboard bench for vec_drain with a behavioural memory model.
module tb_vec_drain;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base;
  logic [15:0] len;
  logic        busy, done, mem_rd, mem_bsy, mem_rvld, out_vld, out_rdy, out_last;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rdata, out_data, sum;

  vec_drain dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_bsy(mem_bsy), .mem_rvld(mem_rvld), .mem_rdata(mem_rdata),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_last(out_last), .sum(sum)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [1024];
  logic [16:0] exp_q [$];
  int          cyc = 0;
  int          n_chk = 0, n_fail = 0;
  int          t_start, done_exp_cyc;
  bit          chk_lat, first_seen, rd_seen, done_seen, aborting;
  int          hs_count, n_acc, n_pop, n_rd;
  logic [15:0] exp_sum;
  logic [9:0]  exp_addr;
  int          rdy_mode, bsy_mode;
  bit          prev_stall, prev_last, prev_hold;
  logic [15:0] prev_data;
  logic [9:0]  prev_addr;

  function automatic void chk(input bit ok, input string nm, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // memory with one-cycle read latency
  always @(posedge clk) begin
    mem_rvld  <= mem_rd && !mem_bsy;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // downstream ready and memory stall patterns
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_rdy = 1'b1;
      1: out_rdy = (cyc % 3 == 0);
      default: out_rdy = ($urandom_range(0, 3) != 0);
    endcase
    case (bsy_mode)
      0: mem_bsy = 1'b0;
      1: mem_bsy = (cyc % 12 < 2);
      default: mem_bsy = ($urandom_range(0, 4) == 0);
    endcase
  end

  // monitor: scoreboard, protocol stability, credit bound, timing of done
  always @(negedge clk) begin
    if (rst || aborting) begin
      prev_stall = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      chk(n_acc - n_pop <= 4, "credit_bound", n_acc - n_pop, 4);
      if (prev_stall) begin
        chk(out_vld, "vld_held", int'(out_vld), 1);
        chk(out_data == prev_data && out_last == prev_last, "data_stable",
            int'(out_data), int'(prev_data));
      end
      if (prev_hold)
        chk(mem_rd && mem_addr == prev_addr, "addr_hold", int'(mem_addr), int'(prev_addr));
      if (mem_rd) n_rd++;
      if (mem_rd && !mem_bsy) begin
        chk(mem_addr == exp_addr, "rd_addr", int'(mem_addr), int'(exp_addr));
        exp_addr = exp_addr + 10'd1;
        n_acc++;
      end
      if (chk_lat && mem_rd && !rd_seen) begin
        chk(cyc == t_start + 1, "first_rd_lat", cyc - t_start, 1);
        chk(busy, "busy_run", int'(busy), 1);
        rd_seen = 1'b1;
      end
      if (chk_lat && out_vld && !first_seen) begin
        chk(cyc == t_start + 3, "first_vld_lat", cyc - t_start, 3);
        first_seen = 1'b1;
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_word", int'(out_data), -1);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk(out_data == e[15:0], "out_data", int'(out_data), int'(e[15:0]));
          chk(out_last == e[16], "out_last", int'(out_last), int'(e[16]));
        end
        exp_sum = exp_sum + out_data;
        hs_count++;
        n_pop++;
        if (out_last) done_exp_cyc = cyc + 1;
      end
      if (done) begin
        chk(cyc == done_exp_cyc, "done_timing", cyc, done_exp_cyc);
        chk(sum == exp_sum, "sum_at_done", int'(sum), int'(exp_sum));
        chk(exp_q.size() == 0, "words_missing", exp_q.size(), 0);
        done_seen = 1'b1;
      end
      prev_stall = out_vld && !out_rdy;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_hold  = mem_rd && mem_bsy;
      prev_addr  = mem_addr;
    end
  end

  task automatic do_start(input logic [9:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    t_start = cyc;
    start = 1'b1; base = b; len = l;
    exp_sum = '0; exp_addr = b; hs_count = 0;
    first_seen = 1'b0; rd_seen = 1'b0; done_seen = 1'b0;
    done_exp_cyc = (l == 0) ? cyc + 1 : -100;
    for (int i = 0; i < int'(l); i++) begin
      logic [9:0] a;
      a = b + 10'(i);
      exp_q.push_back({(i == int'(l) - 1), mem[a]});
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done_seen && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk(done_seen, nm, int'(done_seen), 1);
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk(!busy && !done && !mem_rd && !out_vld && !out_last, {nm, "_ctrl"},
        int'({busy, done, mem_rd, out_vld, out_last}), 0);
    chk(mem_addr == '0 && sum == '0 && out_data == '0, {nm, "_data"},
        int'(mem_addr) + int'(sum) + int'(out_data), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; len = '0;
    rdy_mode = 0; bsy_mode = 0; out_rdy = 1'b1; mem_bsy = 1'b0;
    chk_lat = 1'b0; aborting = 1'b0; exp_sum = '0; exp_addr = '0;
    hs_count = 0; n_acc = 0; n_pop = 0; n_rd = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 5; i++) mem[32 + i] = 16'(i + 1);
    mem[1022] = 16'd10; mem[1023] = 16'd20; mem[0] = 16'd30; mem[1] = 16'd40;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    chk_lat = 1'b1;
    do_start(10'd32, 16'd5);
    wait_done("basic_done");
    chk_lat = 1'b0;
    chk(sum == 16'd15, "basic_sum", int'(sum), 15);

    rdy_mode = 1;
    do_start(10'd32, 16'd5);
    wait_done("bp_done");
    chk(sum == 16'd15, "bp_sum", int'(sum), 15);

    rdy_mode = 0; bsy_mode = 1;
    do_start(10'd32, 16'd5);
    wait_done("stall_done");
    chk(sum == 16'd15, "stall_sum", int'(sum), 15);

    bsy_mode = 0;
    do_start(10'd1022, 16'd4);
    wait_done("wrap_done");
    chk(sum == 16'd100, "wrap_sum", int'(sum), 100);

    begin
      int rd_before;
      rd_before = n_rd;
      do_start(10'd500, 16'd0);
      wait_done("zero_done");
      chk(n_rd == rd_before, "zero_no_reads", n_rd - rd_before, 0);
      chk(sum == 16'd0, "zero_sum", int'(sum), 0);
    end

    rdy_mode = 2; bsy_mode = 2;
    for (int k = 0; k < 6; k++) begin
      do_start(10'($urandom), 16'($urandom_range(1, 24)));
      wait_done("rand_done");
    end

    rdy_mode = 0; bsy_mode = 0;
    do_start(10'd100, 16'd10);
    begin
      int n = 0;
      while (hs_count < 2 && n < 200) begin
        @(posedge clk);
        n++;
      end
      chk(hs_count >= 2, "abort_beats", hs_count, 2);
    end
    #1 aborting = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    n_acc = 0; n_pop = 0; exp_sum = '0;
    aborting = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    @(negedge clk);
    chk(!out_vld, "stale_dropped", int'(out_vld), 0);

    do_start(10'd200, 16'd3);
    @(posedge clk); #1;
    start = 1'b1; base = 10'd600; len = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("after_abort_done");
    chk(hs_count == 3, "after_abort_beats", hs_count, 3);
    repeat (5) @(posedge clk);
    chk(!busy && !out_vld, "ignored_start", int'({busy, out_vld}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
